// File: rtl/time_set_ctl_pkg.sv
// Shared types and constants for the clock/calendar edit controller.
// Holds the edit-state encoding, field LED codes, BCD limits and the common BCD step function.
package time_set_ctl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_E_YR   = 3'd1,
    ST_E_MON  = 3'd2,
    ST_E_DAY  = 3'd3,
    ST_E_HR   = 3'd4,
    ST_E_MIN  = 3'd5,
    ST_COMMIT = 3'd6
  } state_t;

  localparam logic [2:0]  FIELD_RUN  = 3'b000;
  localparam logic [2:0]  FIELD_YR   = 3'b100;
  localparam logic [2:0]  FIELD_DATE = 3'b010;
  localparam logic [2:0]  FIELD_TIME = 3'b001;

  localparam logic [15:0] YR_MIN  = 16'h2000;
  localparam logic [15:0] YR_MAX  = 16'h2099;
  localparam logic [7:0]  MON_MIN = 8'h01;
  localparam logic [7:0]  MON_MAX = 8'h12;
  localparam logic [7:0]  DAY_MIN = 8'h01;
  localparam logic [7:0]  HR_MAX  = 8'h23;
  localparam logic [7:0]  MIN_MAX = 8'h59;
  localparam logic [7:0]  BCD_00  = 8'h00;

  // Four-digit BCD increment; values at or above hi wrap to lo (valid BCD compares like binary).
  function automatic logic [15:0] bcd_inc_wrap(input logic [15:0] val,
                                               input logic [15:0] lo,
                                               input logic [15:0] hi);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val >= hi) begin
      res = lo;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (carry && (res[d*4 +: 4] == 4'd9)) begin
          res[d*4 +: 4] = 4'd0;
        end else if (carry) begin
          res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end else begin
          carry = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == ST_E_YR) || (s == ST_E_MON) || (s == ST_E_DAY) ||
           (s == ST_E_HR) || (s == ST_E_MIN);
  endfunction

endpackage

// File: rtl/time_set_ctl_if.sv
// Button/timebase inputs, live counter values and edit outputs of the time-set controller.
interface time_set_ctl_if;
  logic        tick;
  logic        btn_set;
  logic        btn_inc;
  logic [15:0] cur_year;
  logic [7:0]  cur_month;
  logic [7:0]  cur_day;
  logic [7:0]  cur_hour;
  logic [7:0]  cur_min;
  logic        run_en;
  logic        load;
  logic [15:0] set_year;
  logic [7:0]  set_month;
  logic [7:0]  set_day;
  logic [7:0]  set_hour;
  logic [7:0]  set_min;
  logic [2:0]  field;
  logic        blink;

  modport master (
    output tick, btn_set, btn_inc, cur_year, cur_month, cur_day, cur_hour, cur_min,
    input  run_en, load, set_year, set_month, set_day, set_hour, set_min, field, blink
  );

  modport slave (
    input  tick, btn_set, btn_inc, cur_year, cur_month, cur_day, cur_hour, cur_min,
    output run_en, load, set_year, set_month, set_day, set_hour, set_min, field, blink
  );
endinterface

// File: rtl/time_set_ctl_bcd_days_in_month.sv
// Days in a BCD month for years 2000..2099; also used by the date counter.
module bcd_days_in_month (
  input  logic [7:0] month,
  input  logic [3:0] yr1,
  input  logic [3:0] yr0,
  output logic [7:0] dim
);

  logic leap;

  // Leap from the two low BCD year digits; a non-decimal tens digit is treated as non-leap.
  always_comb begin
    leap = 1'b0;
    if (yr1 > 4'd9) begin
      leap = 1'b0;
    end else if (yr1[0]) begin
      leap = (yr0 == 4'd2) || (yr0 == 4'd6);
    end else begin
      leap = (yr0 == 4'd0) || (yr0 == 4'd4) || (yr0 == 4'd8);
    end
  end

  // Month length lookup.
  always_comb begin
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      8'h02:                      dim = leap ? 8'h29 : 8'h28;
      default:                    dim = 8'h31;
    endcase
  end

endmodule

// File: rtl/time_set_ctl.sv
// Time/date edit controller: freezes the counters, steps one field at a time and commits
// the edited value with a single-cycle parallel load.
module time_set_ctl
  import time_set_ctl_pkg::*;
#(
  parameter int BLINK_TICKS   = 50,
  parameter int TIMEOUT_TICKS = 3000
) (
  input logic          clk,
  input logic          rst_n,
  time_set_ctl_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int BLK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  state_t             state_r, state_s;
  logic [15:0]        yr_r, yr_s;
  logic [7:0]         mon_r, mon_s, day_r, day_s, hr_r, hr_s, min_r, min_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic [BLK_W-1:0]   blk_cnt_r, blk_cnt_s;
  logic               blk_ph_r, blk_ph_s;
  logic               run_en_r, run_en_s, load_r, load_s, blink_r, blink_s;
  logic [2:0]         field_r, field_s;
  logic [7:0]         dim_s;

  bcd_days_in_month u_dim (
    .month (mon_r),
    .yr1   (yr_r[7:4]),
    .yr0   (yr_r[3:0]),
    .dim   (dim_s)
  );

  // Next state, edit registers and idle timeout.
  always_comb begin
    state_s = state_r;
    yr_s    = yr_r;
    mon_s   = mon_r;
    day_s   = day_r;
    hr_s    = hr_r;
    min_s   = min_r;
    tmo_s   = tmo_r;
    case (state_r)
      ST_RUN: begin
        if (bus.btn_set) begin
          yr_s    = bus.cur_year;
          mon_s   = bus.cur_month;
          day_s   = bus.cur_day;
          hr_s    = bus.cur_hour;
          min_s   = bus.cur_min;
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_E_YR;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_COMMIT: state_s = ST_RUN;
      ST_E_YR, ST_E_MON, ST_E_DAY, ST_E_HR, ST_E_MIN: begin
        if (bus.btn_set) begin
          tmo_s = {TMO_W{1'b0}};
          // Leaving month edit pulls an out-of-range day back to the last valid day.
          day_s = ((state_r == ST_E_MON) && (day_r > dim_s)) ? dim_s : day_r;
          case (state_r)
            ST_E_YR:  state_s = ST_E_MON;
            ST_E_MON: state_s = ST_E_DAY;
            ST_E_DAY: state_s = ST_E_HR;
            ST_E_HR:  state_s = ST_E_MIN;
            ST_E_MIN: state_s = ST_COMMIT;
            default:  state_s = ST_RUN;
          endcase
        end else if (bus.btn_inc) begin
          tmo_s = {TMO_W{1'b0}};
          case (state_r)
            ST_E_YR:  yr_s  = bcd_inc_wrap(yr_r, YR_MIN, YR_MAX);
            ST_E_MON: mon_s = 8'(bcd_inc_wrap({8'h00, mon_r}, {8'h00, MON_MIN}, {8'h00, MON_MAX}));
            ST_E_DAY: day_s = 8'(bcd_inc_wrap({8'h00, day_r}, {8'h00, DAY_MIN}, {8'h00, dim_s}));
            ST_E_HR:  hr_s  = 8'(bcd_inc_wrap({8'h00, hr_r}, {8'h00, BCD_00}, {8'h00, HR_MAX}));
            ST_E_MIN: min_s = 8'(bcd_inc_wrap({8'h00, min_r}, {8'h00, BCD_00}, {8'h00, MIN_MAX}));
            default:  yr_s  = yr_r;
          endcase
        end else if (bus.tick) begin
          if (tmo_r == TMO_LAST) begin
            tmo_s   = {TMO_W{1'b0}};
            state_s = ST_RUN;
          end else begin
            tmo_s = tmo_r + TMO_W'(1);
          end
        end else begin
          tmo_s = tmo_r;
        end
      end
      default: state_s = ST_RUN;
    endcase
  end

  // Blink phase and registered output values derived from the next state.
  always_comb begin
    blk_cnt_s = blk_cnt_r;
    blk_ph_s  = blk_ph_r;
    field_s   = FIELD_RUN;
    if (state_s != state_r) begin
      blk_cnt_s = {BLK_W{1'b0}};
      blk_ph_s  = 1'b0;
    end else if (bus.tick && (blk_cnt_r == BLK_LAST)) begin
      blk_cnt_s = {BLK_W{1'b0}};
      blk_ph_s  = ~blk_ph_r;
    end else if (bus.tick) begin
      blk_cnt_s = blk_cnt_r + BLK_W'(1);
    end else begin
      blk_cnt_s = blk_cnt_r;
    end
    case (state_s)
      ST_E_YR:            field_s = FIELD_YR;
      ST_E_MON, ST_E_DAY: field_s = FIELD_DATE;
      ST_E_HR, ST_E_MIN:  field_s = FIELD_TIME;
      default:            field_s = FIELD_RUN;
    endcase
    run_en_s = (state_s == ST_RUN);
    load_s   = (state_s == ST_COMMIT);
    blink_s  = is_edit(state_s) && !bus.btn_inc && blk_ph_s;
  end

  // State, edit values, counters and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      yr_r      <= YR_MIN;
      mon_r     <= MON_MIN;
      day_r     <= DAY_MIN;
      hr_r      <= BCD_00;
      min_r     <= BCD_00;
      tmo_r     <= {TMO_W{1'b0}};
      blk_cnt_r <= {BLK_W{1'b0}};
      blk_ph_r  <= 1'b0;
      run_en_r  <= 1'b1;
      load_r    <= 1'b0;
      blink_r   <= 1'b0;
      field_r   <= FIELD_RUN;
    end else begin
      state_r   <= state_s;
      yr_r      <= yr_s;
      mon_r     <= mon_s;
      day_r     <= day_s;
      hr_r      <= hr_s;
      min_r     <= min_s;
      tmo_r     <= tmo_s;
      blk_cnt_r <= blk_cnt_s;
      blk_ph_r  <= blk_ph_s;
      run_en_r  <= run_en_s;
      load_r    <= load_s;
      blink_r   <= blink_s;
      field_r   <= field_s;
    end
  end

  assign bus.run_en    = run_en_r;
  assign bus.load      = load_r;
  assign bus.blink     = blink_r;
  assign bus.field     = field_r;
  assign bus.set_year  = yr_r;
  assign bus.set_month = mon_r;
  assign bus.set_day   = day_r;
  assign bus.set_hour  = hr_r;
  assign bus.set_min   = min_r;

endmodule

// File: tb/tb_time_set_ctl.sv
// Bench for time_set_ctl: directed scenarios plus random buttons, all checked each cycle
// against a calendar-level model that works on plain integers.
module tb_time_set_ctl;

  localparam int BLINK = 4;
  localparam int TMO   = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_set_ctl_if bus ();

  time_set_ctl #(.BLINK_TICKS(BLINK), .TIMEOUT_TICKS(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  // Model: phase 0 running, 1..5 editing year..minute, 6 committing.
  int m_ph, m_y, m_mo, m_d, m_h, m_mi, m_tmo, m_blk;
  bit m_inc;
  int c_y, c_mo, c_d, c_h, c_mi;
  int load_cnt, load_at, ret_at;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [15:0] bcd4(input int v);
    return {bcd2(v / 100), bcd2(v % 100)};
  endfunction

  function automatic int dim_of(input int mo, input int y);
    if (mo == 2) return (y % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi);
    c_y = y; c_mo = mo; c_d = d; c_h = h; c_mi = mi;
  endtask

  task automatic model_reset();
    m_ph = 0; m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0;
    m_tmo = 0; m_blk = 0; m_inc = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit i, input bit t);
    int prev;
    prev = m_ph;
    if (m_ph == 0) begin
      if (s) begin
        m_y = c_y; m_mo = c_mo; m_d = c_d; m_h = c_h; m_mi = c_mi;
        m_ph = 1; m_tmo = 0;
      end
    end else if (m_ph == 6) begin
      m_ph = 0;
    end else if (s) begin
      if (m_ph == 2 && m_d > dim_of(m_mo, m_y)) m_d = dim_of(m_mo, m_y);
      m_ph++;
      m_tmo = 0;
    end else if (i) begin
      case (m_ph)
        1: m_y  = (m_y == 2099) ? 2000 : m_y + 1;
        2: m_mo = (m_mo == 12) ? 1 : m_mo + 1;
        3: m_d  = (m_d >= dim_of(m_mo, m_y)) ? 1 : m_d + 1;
        4: m_h  = (m_h == 23) ? 0 : m_h + 1;
        default: m_mi = (m_mi == 59) ? 0 : m_mi + 1;
      endcase
      m_tmo = 0;
    end else if (t) begin
      m_tmo++;
      if (m_tmo == TMO) begin
        m_ph = 0;
        m_tmo = 0;
      end
    end
    if (m_ph != prev) m_blk = 0;
    else if (t) m_blk++;
    m_inc = i;
  endtask

  task automatic check_all();
    logic [2:0] f;
    bit edit;
    edit = (m_ph >= 1 && m_ph <= 5);
    case (m_ph)
      1:       f = 3'b100;
      2, 3:    f = 3'b010;
      4, 5:    f = 3'b001;
      default: f = 3'b000;
    endcase
    check_val("run_en", 16'(bus.run_en), 16'(m_ph == 0));
    check_val("load",   16'(bus.load),   16'(m_ph == 6));
    check_val("field",  16'(bus.field),  16'(f));
    check_val("blink",  16'(bus.blink),  16'(edit && !m_inc && ((m_blk / BLINK) % 2 == 1)));
    check_val("set_year",  bus.set_year,         bcd4(m_y));
    check_val("set_month", 16'(bus.set_month),   16'(bcd2(m_mo)));
    check_val("set_day",   16'(bus.set_day),     16'(bcd2(m_d)));
    check_val("set_hour",  16'(bus.set_hour),    16'(bcd2(m_h)));
    check_val("set_min",   16'(bus.set_min),     16'(bcd2(m_mi)));
  endtask

  task automatic step(input bit s, input bit i, input bit t);
    @(negedge clk);
    bus.btn_set   = s;
    bus.btn_inc   = i;
    bus.tick      = t;
    bus.cur_year  = bcd4(c_y);
    bus.cur_month = bcd2(c_mo);
    bus.cur_day   = bcd2(c_d);
    bus.cur_hour  = bcd2(c_h);
    bus.cur_min   = bcd2(c_mi);
    @(posedge clk);
    model_step(s, i, t);
    #1;
    check_all();
    bus.btn_set = 1'b0;
    bus.btn_inc = 1'b0;
    bus.tick    = 1'b0;
  endtask

  initial begin
    int incs[3];
    int yrs[3];
    int exp_d[3];
    bus.btn_set = 1'b0;
    bus.btn_inc = 1'b0;
    bus.tick    = 1'b0;
    set_cur(2011, 5, 6, 7, 8);
    bus.cur_year = bcd4(c_y); bus.cur_month = bcd2(c_mo); bus.cur_day = bcd2(c_d);
    bus.cur_hour = bcd2(c_h); bus.cur_min = bcd2(c_mi);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check_val("rst_year", bus.set_year, 16'h2000);
    @(negedge clk);
    rst_n = 1'b1;

    // Full pass: exactly one load, on the edge of the sixth set pulse.
    set_cur(2023, 4, 30, 13, 59);
    load_cnt = 0;
    load_at  = -1;
    for (int k = 0; k < 10; k++) begin
      step(k < 6, 1'b0, 1'b0);
      if (bus.load) begin
        load_cnt++;
        if (load_at < 0) load_at = k;
      end
    end
    check_val("load_count", 16'(load_cnt), 16'd1);
    check_val("load_step",  16'(load_at),  16'd5);
    check_val("cap_year", bus.set_year, 16'h2023);
    check_val("cap_day",  16'(bus.set_day), 16'h0030);
    check_val("cap_min",  16'(bus.set_min), 16'h0059);

    // Wrap boundaries of every field except day.
    set_cur(2099, 12, 15, 23, 59);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("yr_wrap", bus.set_year, 16'h2000);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("mon_wrap", 16'(bus.set_month), 16'h0001);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("hr_wrap", 16'(bus.set_hour), 16'h0000);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("min_wrap", 16'(bus.set_min), 16'h0000);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Day 31 clamped to February length when leaving month edit.
    yrs   = '{2023, 2023, 2099};
    incs  = '{0, 1, 1};
    exp_d = '{28, 29, 29};
    for (int n = 0; n < 3; n++) begin
      set_cur(yrs[n], 1, 31, 10, 10);
      step(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < incs[n]; j++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check_val("feb_clamp", 16'(bus.set_day), 16'(bcd2(exp_d[n])));
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Set wins over inc; then idle ticks abort the edit without a load.
    set_cur(2024, 6, 15, 12, 34);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_val("setinc_hour",  16'(bus.set_hour), 16'h0012);
    check_val("setinc_field", 16'(bus.field),    16'h0001);
    load_cnt = 0;
    ret_at   = -1;
    for (int k = 0; k < TMO + 5 && ret_at < 0; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.load) load_cnt++;
      if (bus.run_en) ret_at = k;
    end
    check_val("tmo_noload", 16'(load_cnt), 16'd0);
    check_val("tmo_step",   16'(ret_at),   16'(TMO - 1));
    check_val("tmo_hold",   16'(bus.set_min), 16'h0034);

    // Asynchronous reset in the middle of day edit.
    set_cur(2022, 8, 20, 7, 45);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst_mid_day", 16'(bus.set_day), 16'h0001);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Random buttons, ticks and live counter values.
    for (int k = 0; k < 1500; k++) begin
      int y, mo;
      y  = 2000 + int'($urandom_range(0, 99));
      mo = int'($urandom_range(1, 12));
      set_cur(y, mo, int'($urandom_range(1, dim_of(mo, y))),
              int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
